// File: rtl/mem_access_unit.sv
// Memory-access stage: consumes the EX/MA register, runs word loads/stores over a
// req/gnt data bus, stalls upstream while a transaction is pending, and drives MA/WB.
module mem_access_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  ma_pc_plus_4_in,
    input  logic [XLEN-1:0]  ma_alu_result_in,
    input  logic [XLEN-1:0]  ma_write_data_in,
    input  logic [4:0]       ma_rd_addr_in,
    input  logic             ma_mem_read_in,
    input  logic             ma_mem_write_in,
    input  logic             ma_reg_write_in,
    input  logic             ma_mem_to_reg_in,
    output logic             dbus_req,
    output logic             dbus_we,
    output logic [XLEN-1:0]  dbus_addr,
    output logic [XLEN-1:0]  dbus_wdata,
    input  logic             dbus_gnt,
    input  logic [XLEN-1:0]  dbus_rdata,
    output logic             stall_out,
    output logic             mem_err_out,
    output logic [XLEN-1:0]  wb_pc_plus_4_out,
    output logic [XLEN-1:0]  wb_alu_result_out,
    output logic [XLEN-1:0]  wb_mem_data_out,
    output logic [4:0]       wb_rd_addr_out,
    output logic             wb_reg_write_out,
    output logic             wb_mem_to_reg_out,
    output logic [CNT_W-1:0] stall_cycles_out
);

    // state | meaning
    // IDLE  | accepting a new instruction from EX/MA
    // REQ   | bus request outstanding, waiting for dbus_gnt
    // RESP  | access done, held instruction retires into WB
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t          state_q, state_d;
    logic            mem_op, bad;
    logic [XLEN-1:0] rdata_q;

    assign mem_op = ma_mem_read_in | ma_mem_write_in;
    assign bad    = mem_op & ((ma_alu_result_in[1:0] != 2'b00) |
                              (ma_mem_read_in & ma_mem_write_in));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        stall_out = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op && !bad) begin
                    stall_out = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                stall_out = 1'b1;
                if (dbus_gnt) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbus_req          <= 1'b0;
            dbus_we           <= 1'b0;
            dbus_addr         <= '0;
            dbus_wdata        <= '0;
            rdata_q           <= '0;
            mem_err_out       <= 1'b0;
            wb_pc_plus_4_out  <= '0;
            wb_alu_result_out <= '0;
            wb_mem_data_out   <= '0;
            wb_rd_addr_out    <= '0;
            wb_reg_write_out  <= 1'b0;
            wb_mem_to_reg_out <= 1'b0;
            stall_cycles_out  <= '0;
        end else begin
            mem_err_out       <= 1'b0;
            // Non-enable WB fields always follow the input; bubbles are made by reg_write alone.
            wb_pc_plus_4_out  <= ma_pc_plus_4_in;
            wb_alu_result_out <= ma_alu_result_in;
            wb_rd_addr_out    <= ma_rd_addr_in;
            wb_mem_to_reg_out <= ma_mem_to_reg_in;
            wb_mem_data_out   <= '0;
            wb_reg_write_out  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!mem_op) begin
                        wb_reg_write_out <= ma_reg_write_in;
                    end else if (bad) begin
                        mem_err_out <= 1'b1;
                    end else begin
                        dbus_req   <= 1'b1;
                        dbus_we    <= ma_mem_write_in;
                        dbus_addr  <= {ma_alu_result_in[XLEN-1:2], 2'b00};
                        dbus_wdata <= ma_write_data_in;
                    end
                end
                REQ: begin
                    if (dbus_gnt) begin
                        dbus_req <= 1'b0;
                        rdata_q  <= dbus_we ? '0 : dbus_rdata;
                    end
                end
                RESP: begin
                    wb_reg_write_out <= ma_reg_write_in;
                    wb_mem_data_out  <= rdata_q;
                end
                default: ;
            endcase
            if (stall_out && (stall_cycles_out != '1))
                stall_cycles_out <= stall_cycles_out + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expected WB results and bus
// requests into queues; negedge monitors pop and compare as the DUT presents them.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ma_pc_plus_4_in = '0, ma_alu_result_in = '0, ma_write_data_in = '0;
    logic [4:0]  ma_rd_addr_in = '0;
    logic        ma_mem_read_in = 1'b0, ma_mem_write_in = 1'b0;
    logic        ma_reg_write_in = 1'b0, ma_mem_to_reg_in = 1'b0;
    logic        dbus_req, dbus_we, dbus_gnt = 1'b0;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata = '0;
    logic        stall_out, mem_err_out;
    logic [31:0] wb_pc_plus_4_out, wb_alu_result_out, wb_mem_data_out;
    logic [4:0]  wb_rd_addr_out;
    logic        wb_reg_write_out, wb_mem_to_reg_out;
    logic [3:0]  stall_cycles_out;

    mem_access_unit #(.XLEN(32), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .ma_pc_plus_4_in(ma_pc_plus_4_in), .ma_alu_result_in(ma_alu_result_in),
        .ma_write_data_in(ma_write_data_in), .ma_rd_addr_in(ma_rd_addr_in),
        .ma_mem_read_in(ma_mem_read_in), .ma_mem_write_in(ma_mem_write_in),
        .ma_reg_write_in(ma_reg_write_in), .ma_mem_to_reg_in(ma_mem_to_reg_in),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_wdata(dbus_wdata), .dbus_gnt(dbus_gnt), .dbus_rdata(dbus_rdata),
        .stall_out(stall_out), .mem_err_out(mem_err_out),
        .wb_pc_plus_4_out(wb_pc_plus_4_out), .wb_alu_result_out(wb_alu_result_out),
        .wb_mem_data_out(wb_mem_data_out), .wb_rd_addr_out(wb_rd_addr_out),
        .wb_reg_write_out(wb_reg_write_out), .wb_mem_to_reg_out(wb_mem_to_reg_out),
        .stall_cycles_out(stall_cycles_out)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int exp_err_cycles = 0;
    int err_cycles     = 0;
    int cnt_model      = 0;

    logic [101:0] wb_q[$];
    logic [64:0]  bus_q[$];
    logic [64:0]  bus_held = '0;
    logic         prev_req = 1'b0;
    logic         gnt_at_edge;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) gnt_at_edge <= 1'b0;
        else     gnt_at_edge <= dbus_gnt & dbus_req;
    end

    // WB monitor: every writeback must match the oldest outstanding expectation.
    initial forever begin
        @(negedge clk);
        if (!rst && mem_err_out) err_cycles++;
        if (!rst && wb_reg_write_out) begin
            if (wb_q.size() == 0) begin
                n_total++; n_bad++;
                $display("FAIL wb_unexpected: got rd=%0d alu=%0h expected none",
                         wb_rd_addr_out, wb_alu_result_out);
            end else begin
                chk("wb", {wb_pc_plus_4_out, wb_alu_result_out, wb_mem_data_out,
                           wb_rd_addr_out, wb_mem_to_reg_out}, wb_q.pop_front());
            end
        end
    end

    // Bus monitor: new requests match expectations, held requests stay stable,
    // and no request appears in the cycle after a grant.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            prev_req = 1'b0;
        end else begin
            if (gnt_at_edge) chk("req_gap", dbus_req, 1'b0);
            if (dbus_req && !prev_req) begin
                if (bus_q.size() == 0) begin
                    n_total++; n_bad++;
                    $display("FAIL bus_unexpected: got addr=%0h expected no request", dbus_addr);
                end else begin
                    bus_held = bus_q.pop_front();
                    chk("bus_req", {dbus_we, dbus_addr, dbus_wdata}, bus_held);
                end
            end else if (dbus_req) begin
                chk("bus_hold", {dbus_we, dbus_addr, dbus_wdata}, bus_held);
            end
            prev_req = dbus_req;
        end
    end

    task automatic drive_nop();
        ma_pc_plus_4_in = '0; ma_alu_result_in = '0; ma_write_data_in = '0;
        ma_rd_addr_in = '0; ma_mem_read_in = 0; ma_mem_write_in = 0;
        ma_reg_write_in = 0; ma_mem_to_reg_in = 0;
    endtask

    // Called at posedge+1; holds the instruction while stalled, returns at posedge+1.
    task automatic run_op(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] wd,
                          input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
                          input logic m2r, input int gnt_wait, input logic [31:0] rdata);
        logic op, is_bad, good, s;
        int st, rq, n, exp_st;
        ma_pc_plus_4_in = pc; ma_alu_result_in = alu; ma_write_data_in = wd;
        ma_rd_addr_in = rd; ma_reg_write_in = rw; ma_mem_read_in = mr;
        ma_mem_write_in = mw; ma_mem_to_reg_in = m2r;
        dbus_rdata = rdata;
        op     = mr | mw;
        is_bad = op && ((alu[1:0] != 2'b00) || (mr && mw));
        good   = op && !is_bad;
        if (good) bus_q.push_back({mw, alu[31:2], 2'b00, wd});
        if (rw && !is_bad) wb_q.push_back({pc, alu, (good && mr) ? rdata : 32'h0, rd, m2r});
        if (is_bad) exp_err_cycles++;
        st = 0; rq = 0; n = 0;
        do begin
            @(negedge clk);
            s = stall_out;
            if (s) st++;
            if (dbus_req) begin
                rq++;
                if (rq == gnt_wait) dbus_gnt = 1'b1;
            end
            @(posedge clk);
            #1 dbus_gnt = 1'b0;
            n++;
        end while (s && n < 100);
        if (s) begin
            n_total++; n_bad++;
            $display("FAIL op_timeout: got stall after %0d cycles expected release", n);
        end
        drive_nop();
        exp_st = good ? 1 + gnt_wait : 0;
        cnt_model = (cnt_model + exp_st > 15) ? 15 : cnt_model + exp_st;
        chk("stall_len", st, exp_st);
        chk("req_len", rq, good ? gnt_wait : 0);
        chk("stall_cnt", stall_cycles_out, cnt_model);
        if (is_bad) chk("bad_op", {mem_err_out, wb_reg_write_out, dbus_req}, 3'b100);
        if (good && mw) chk("store_no_wb", wb_reg_write_out, 1'b0);
    endtask

    initial begin
        drive_nop();
        #2;
        chk("rst_bus", {dbus_req, dbus_we, dbus_addr, dbus_wdata}, '0);
        chk("rst_wb", {wb_pc_plus_4_out, wb_alu_result_out, wb_mem_data_out}, '0);
        chk("rst_misc", {wb_rd_addr_out, wb_reg_write_out, wb_mem_to_reg_out,
                         mem_err_out, stall_cycles_out, stall_out}, '0);
        #10 rst = 1'b0;
        @(posedge clk); #1;

        //      pc            alu           wdata         rd rw mr mw m2r gnt rdata
        run_op(32'h0000_0044, 32'h0000_1234, 32'h0,        5, 1, 0, 0, 0, 0, 32'h0);
        run_op(32'h0000_0048, 32'h0000_0100, 32'h0,        7, 1, 1, 0, 1, 3, 32'hDEAD_BEEF);
        run_op(32'h0000_004C, 32'h0000_0204, 32'hCAFE_F00D, 0, 0, 0, 1, 0, 1, 32'h5555_5555);
        run_op(32'h0000_0050, 32'h0000_0102, 32'h0,        8, 1, 1, 0, 1, 0, 32'h0);
        run_op(32'h0000_0054, 32'h0000_0200, 32'h1,        9, 1, 1, 1, 1, 0, 32'h0);
        run_op(32'h0000_0058, 32'h0000_0010, 32'h0,       10, 1, 1, 0, 1, 1, 32'h1111_1111);
        run_op(32'h0000_005C, 32'h0000_0014, 32'h0,       11, 1, 1, 0, 1, 2, 32'h2222_2222);
        run_op(32'h0000_0060, 32'h0000_0ABC, 32'h0,       12, 1, 0, 0, 0, 0, 32'h0);
        run_op(32'h0000_0064, 32'hFFFF_FFFC, 32'h0,       13, 1, 1, 0, 1, 10, 32'h0BAD_F00D);

        // Reset in the middle of a REQ phase, then a stray grant.
        ma_pc_plus_4_in = 32'h68; ma_alu_result_in = 32'h300; ma_rd_addr_in = 14;
        ma_reg_write_in = 1; ma_mem_read_in = 1; ma_mem_to_reg_in = 1;
        bus_q.push_back({1'b0, 32'h300, 32'h0});
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_req", dbus_req, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_bus", {dbus_req, dbus_we, dbus_addr, dbus_wdata}, '0);
        chk("mid_rst_wb", {wb_pc_plus_4_out, wb_alu_result_out, wb_mem_data_out}, '0);
        chk("mid_rst_misc", {wb_rd_addr_out, wb_reg_write_out, wb_mem_to_reg_out,
                             mem_err_out, stall_cycles_out}, '0);
        drive_nop();
        @(posedge clk); #1 rst = 1'b0;
        cnt_model = 0;
        @(negedge clk) dbus_gnt = 1'b1;
        @(posedge clk); #1 dbus_gnt = 1'b0;
        @(negedge clk);
        chk("post_rst", {dbus_req, wb_reg_write_out, stall_out, stall_cycles_out}, '0);
        @(posedge clk); #1;

        run_op(32'h0000_0070, 32'h0000_0777, 32'h0,       15, 1, 0, 0, 0, 0, 32'h0);
        run_op(32'h0000_0074, 32'h0000_0020, 32'h0,       16, 1, 1, 0, 1, 1, 32'h3333_3333);

        repeat (4) @(posedge clk);
        #1;
        chk("wb_q_empty", wb_q.size(), 0);
        chk("bus_q_empty", bus_q.size(), 0);
        chk("err_cycles", err_cycles, exp_err_cycles);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
